// File: rtl/tge_arb_pkg.sv
// Shared types, widths and the round-robin helper for the TGE transmit arbiter
// and its companion RX distributor.
package tge_arb_pkg;

  localparam int unsigned TGE_DATA_W    = 64;
  localparam int unsigned TGE_IP_W      = 32;
  localparam int unsigned TGE_PORT_W    = 16;
  localparam int unsigned TGE_MAX_PORTS = 8;
  localparam int unsigned TGE_IDX_W     = 3;
  localparam int unsigned TGE_PKT_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  // One requester beat as seen through the owner mux.
  typedef struct packed {
    logic                  valid;
    logic                  eof;
    logic [TGE_DATA_W-1:0] data;
    logic [TGE_IP_W-1:0]   ip;
    logic [TGE_PORT_W-1:0] port;
  } tge_beat_t;

  // First requester after 'last' in circular order over n ports; 'last' when none request.
  function automatic logic [TGE_IDX_W-1:0] rr_next(
    input logic [TGE_MAX_PORTS-1:0] req,
    input logic [TGE_IDX_W-1:0]     last,
    input int unsigned              n
  );
    int unsigned cand;
    logic        found;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= TGE_MAX_PORTS; k++) begin
      cand = (32'(last) + k) % n;
      if (k <= n && !found && req[cand[TGE_IDX_W-1:0]]) begin
        rr_next = cand[TGE_IDX_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tge_rr_pick.sv
// Combinational round-robin selector.
//   req_i        : request vector, one bit per port
//   last_i       : index granted most recently (search starts just after it)
//   pick_valid_c : at least one port requests
//   pick_idx_c   : index of the winning port
module tge_rr_pick
  import tge_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]           req_i,
  input  logic [TGE_IDX_W-1:0]   last_i,
  output logic                   pick_valid_c,
  output logic [TGE_IDX_W-1:0]   pick_idx_c
);

  logic [TGE_MAX_PORTS-1:0] req_ext;

  assign req_ext      = TGE_MAX_PORTS'(req_i);
  assign pick_valid_c = |req_i;
  assign pick_idx_c   = rr_next(req_ext, last_i, N);

endmodule

// File: rtl/tge_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one 10GbE core transmit port.
//   clk, rst_n          : application clock, async active-low reset
//   req_*               : per-requester beat, EOF, data, dest IP/port; req_ready back
//   tx_*                : registered beat stream into the core; tx_afull/tx_overflow from it
//   grant               : one-hot current owner, 0 when idle
//   trunc_pulse         : packet cut at MAX_BEATS
//   overflow_sticky/clr : latched core overflow and its clear
//   pkt_count           : packets forwarded, wrapping
module tge_tx_arbiter
  import tge_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned MAX_BEATS = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_PORTS-1:0]              req_valid,
  input  logic [N_PORTS-1:0]              req_end_of_frame,
  input  logic [TGE_DATA_W*N_PORTS-1:0]   req_data,
  input  logic [TGE_IP_W*N_PORTS-1:0]     req_dest_ip,
  input  logic [TGE_PORT_W*N_PORTS-1:0]   req_dest_port,
  output logic [N_PORTS-1:0]              req_ready,
  output logic                            tx_valid,
  output logic                            tx_end_of_frame,
  output logic [TGE_DATA_W-1:0]           tx_data,
  output logic [TGE_IP_W-1:0]             tx_dest_ip,
  output logic [TGE_PORT_W-1:0]           tx_dest_port,
  input  logic                            tx_afull,
  input  logic                            tx_overflow,
  output logic [N_PORTS-1:0]              grant,
  output logic                            trunc_pulse,
  output logic                            overflow_sticky,
  input  logic                            overflow_clr,
  output logic [TGE_PKT_W-1:0]            pkt_count
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_e              state_q, state_d;
  logic [TGE_IDX_W-1:0]    last_q, last_d;
  logic [TGE_IDX_W-1:0]    gidx_q, gidx_d;
  logic [N_PORTS-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    tx_eof_q, tx_eof_d;
  logic [TGE_DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [TGE_IP_W-1:0]     tx_ip_q, tx_ip_d;
  logic [TGE_PORT_W-1:0]   tx_port_q, tx_port_d;
  logic                    trunc_q, trunc_d;
  logic                    ovf_q, ovf_d;
  logic [TGE_PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                    pick_valid;
  logic [TGE_IDX_W-1:0]    pick_idx;
  tge_beat_t               sel;

  tge_rr_pick #(.N(N_PORTS)) u_pick (
    .req_i        (req_valid),
    .last_i       (last_q),
    .pick_valid_c (pick_valid),
    .pick_idx_c   (pick_idx)
  );

  // Owner's lanes.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (gidx_q == TGE_IDX_W'(i)) begin
        sel.valid = req_valid[i];
        sel.eof   = req_end_of_frame[i];
        sel.data  = req_data[i*TGE_DATA_W +: TGE_DATA_W];
        sel.ip    = req_dest_ip[i*TGE_IP_W +: TGE_IP_W];
        sel.port  = req_dest_port[i*TGE_PORT_W +: TGE_PORT_W];
      end
    end
  end

  // Next-state, ready and output-stage logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    tx_valid_d = 1'b0;
    tx_eof_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_ip_d    = tx_ip_q;
    tx_port_d  = tx_port_q;
    trunc_d    = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    req_ready  = '0;
    // Set beats clear when both arrive together.
    ovf_d      = tx_overflow ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = STREAM;
          gidx_d     = pick_idx;
          last_d     = pick_idx;
          grant_d    = N_PORTS'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      STREAM: begin
        req_ready = tx_afull ? '0 : grant_q;
        if (sel.valid && !tx_afull) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sel.data;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == '0) begin
            tx_ip_d   = sel.ip;
            tx_port_d = sel.port;
          end
          if (sel.eof) begin
            tx_eof_d  = 1'b1;
            pkt_cnt_d = pkt_cnt_q + TGE_PKT_W'(1);
            state_d   = IDLE;
            grant_d   = '0;
          end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            // Last allowed beat: close the frame at the core and swallow the rest.
            tx_eof_d  = 1'b1;
            trunc_d   = 1'b1;
            pkt_cnt_d = pkt_cnt_q + TGE_PKT_W'(1);
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        req_ready = grant_q;
        if (sel.valid && sel.eof) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= TGE_IDX_W'(N_PORTS - 1);
      gidx_q     <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_eof_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_ip_q    <= '0;
      tx_port_q  <= '0;
      trunc_q    <= 1'b0;
      ovf_q      <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_eof_q   <= tx_eof_d;
      tx_data_q  <= tx_data_d;
      tx_ip_q    <= tx_ip_d;
      tx_port_q  <= tx_port_d;
      trunc_q    <= trunc_d;
      ovf_q      <= ovf_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign tx_valid        = tx_valid_q;
  assign tx_end_of_frame = tx_eof_q;
  assign tx_data         = tx_data_q;
  assign tx_dest_ip      = tx_ip_q;
  assign tx_dest_port    = tx_port_q;
  assign grant           = grant_q;
  assign trunc_pulse     = trunc_q;
  assign overflow_sticky = ovf_q;
  assign pkt_count       = pkt_cnt_q;

endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Scoreboard bench for tge_tx_arbiter: packets queued per port, expected output
// beats queued in grant order, a negedge monitor pops and compares.
module tb_tge_tx_arbiter;

  localparam int NP   = 4;
  localparam int MAXB = 1024;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
  } tb_beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_end_of_frame = '0;
  logic [64*NP-1:0]  req_data = '0;
  logic [32*NP-1:0]  req_dest_ip = '0;
  logic [16*NP-1:0]  req_dest_port = '0;
  logic [NP-1:0]     req_ready;
  logic              tx_valid, tx_end_of_frame;
  logic [63:0]       tx_data;
  logic [31:0]       tx_dest_ip;
  logic [15:0]       tx_dest_port;
  logic              tx_afull = 1'b0;
  logic              tx_overflow = 1'b0;
  logic [NP-1:0]     grant;
  logic              trunc_pulse, overflow_sticky;
  logic              overflow_clr = 1'b0;
  logic [31:0]       pkt_count;

  tge_tx_arbiter #(.N_PORTS(NP), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_end_of_frame(req_end_of_frame), .req_data(req_data),
    .req_dest_ip(req_dest_ip), .req_dest_port(req_dest_port), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame), .tx_data(tx_data),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
    .tx_afull(tx_afull), .tx_overflow(tx_overflow),
    .grant(grant), .trunc_pulse(trunc_pulse),
    .overflow_sticky(overflow_sticky), .overflow_clr(overflow_clr),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass = 0;
  int            exp_pkts = 0;
  tb_beat_t      pq [NP][$];
  tb_beat_t      exp_q[$];
  logic [NP-1:0] grant_log[$];
  int            gap_q[$];
  int            intra_gaps = 0;
  int            trunc_cnt = 0;
  logic [63:0]   trunc_data = '0;
  logic          trunc_eof = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name, input int cyc);
    n_checks++;
    $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding", name, cyc, exp_q.size());
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (pq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Queue a packet on port p and the beats the core should see from it.
  task automatic add_pkt(input int p, input int n, input logic [63:0] base,
                         input logic [31:0] ip, input logic [15:0] dport);
    tb_beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.data = base + 64'(i);
      b.eof  = (i == n);
      b.ip   = ip;
      b.port = dport;
      pq[p].push_back(b);
      if (i <= MAXB) begin
        b.eof = (i == n) || (i == MAXB);
        exp_q.push_back(b);
      end
    end
    exp_pkts++;
  endtask

  // Requester driver: present each port's head beat, retire it once accepted.
  initial begin
    logic [NP-1:0] acc;
    tb_beat_t      b;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          b = pq[p][0];
          req_valid[p]               = 1'b1;
          req_end_of_frame[p]        = b.eof;
          req_data[p*64 +: 64]       = b.data;
          req_dest_ip[p*32 +: 32]    = b.ip;
          req_dest_port[p*16 +: 16]  = b.port;
        end else begin
          req_valid[p]        = 1'b0;
          req_end_of_frame[p] = 1'b0;
        end
      end
    end
  end

  // Output monitor.
  logic          after_eof = 1'b0;
  logic          in_pkt = 1'b0;
  int            gap = 0;
  logic [NP-1:0] prev_grant = '0;
  always @(negedge clk) begin
    tb_beat_t got, want;
    if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
    prev_grant = grant;
    if (trunc_pulse) begin
      trunc_cnt++;
      trunc_data = tx_data;
      trunc_eof  = tx_end_of_frame;
    end
    if (tx_valid) begin
      got = {tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h with nothing expected", got);
      end else begin
        want = exp_q.pop_front();
        check("beat", 128'(got), 128'(want));
      end
      if (after_eof) gap_q.push_back(gap);
      gap       = 0;
      after_eof = tx_end_of_frame;
      in_pkt    = !tx_end_of_frame;
    end else if (in_pkt) begin
      intra_gaps++;
    end else begin
      gap++;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (!(all_empty() && exp_q.size() == 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) timeout_fail(name, cyc);
    repeat (2) @(negedge clk);
  endtask

  // Called at posedge+3: assert reset, check outputs asynchronously, release two edges later.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_rst_tx"},
          128'({tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port}), 128'(0));
    check({name, "_rst_ctl"},
          128'({grant, req_ready, trunc_pulse, overflow_sticky, pkt_count}), 128'(0));
    for (int p = 0; p < NP; p++) pq[p].delete();
    exp_q.delete();
    exp_pkts = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk);
    #3;
    do_reset(name);
  endtask

  initial begin
    int             cyc, g0, gs, gp, t0;
    logic [NP-1:0]  exp_g [8];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    apply_reset("init");

    // Single 4-beat packet from port 0.
    add_pkt(0, 4, 64'h0, 32'h0A00_0001, 16'h1234);
    cyc = 0;
    while (!req_valid[0] && cyc < 20) begin @(negedge clk); cyc++; end
    check("t1_grant_idle", 128'(grant), 128'(0));
    check("t1_ready_idle", 128'(req_ready), 128'(0));
    g0 = intra_gaps;
    @(negedge clk);
    check("t1_grant", 128'(grant), 128'(4'b0001));
    check("t1_ready", 128'(req_ready), 128'(4'b0001));
    wait_done("t1", 50);
    check("t1_intra_gaps", 128'(intra_gaps - g0), 128'(0));
    check("t1_pkt_count", 128'(pkt_count), 128'(exp_pkts));

    // All ports stream 2-beat packets back to back.
    apply_reset("t2");
    gs = grant_log.size();
    gp = gap_q.size();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        add_pkt(p, 2, {8'(p), 8'(r), 48'h0}, 32'hC0A8_0000 + 32'(p), 16'h2000 + 16'(p));
    wait_done("t2", 200);
    check("t2_pkt_count", 128'(pkt_count), 128'(8));
    check("t2_grant_cnt", 128'(grant_log.size() - gs), 128'(8));
    for (int i = 0; i < 8; i++)
      if (gs + i < grant_log.size()) check("t2_grant_order", 128'(grant_log[gs+i]), 128'(exp_g[i]));
    check("t2_gap_cnt", 128'(gap_q.size() - gp), 128'(8));
    for (int i = 1; i < 8; i++)
      if (gp + i < gap_q.size()) check("t2_idle_gap", 128'(gap_q[gp+i]), 128'(1));

    // Backpressure for 5 cycles in the middle of an 8-beat packet.
    g0 = intra_gaps;
    add_pkt(2, 8, 64'h3300_0000_0000_0000, 32'h0A00_0102, 16'h3333);
    cyc = 0;
    while (pq[2].size() > 5 && cyc < 50) begin @(posedge clk); #2; cyc++; end
    if (cyc >= 50) timeout_fail("t3_start", cyc);
    tx_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready_low", 128'(req_ready), 128'(0));
      @(posedge clk);
      #2;
    end
    tx_afull = 1'b0;
    wait_done("t3", 100);
    check("t3_stall_cycles", 128'(intra_gaps - g0), 128'(5));
    check("t3_pkt_count", 128'(pkt_count), 128'(exp_pkts));

    // Oversized packet from port 1, port 2 waiting behind it.
    t0 = trunc_cnt;
    add_pkt(1, 1030, 64'h1100_0000_0000_0000, 32'h0A00_0201, 16'h1111);
    add_pkt(2, 2, 64'h2200_0000_0000_0000, 32'h0A00_0202, 16'h2222);
    wait_done("t4", 3000);
    check("t4_trunc_cnt", 128'(trunc_cnt - t0), 128'(1));
    check("t4_trunc_data", 128'(trunc_data), 128'(64'h1100_0000_0000_0400));
    check("t4_trunc_eof", 128'(trunc_eof), 128'(1));
    check("t4_pkt_count", 128'(pkt_count), 128'(exp_pkts));
    if (grant_log.size() >= 2) begin
      check("t4_grant_trunc", 128'(grant_log[grant_log.size()-2]), 128'(4'b0010));
      check("t4_grant_next", 128'(grant_log[grant_log.size()-1]), 128'(4'b0100));
    end else timeout_fail("t4_grant_log", 0);

    // Overflow sticky: set, set-with-clear, clear.
    @(posedge clk); #2;
    check("t5_sticky_init", 128'(overflow_sticky), 128'(0));
    tx_overflow = 1'b1;
    @(posedge clk); #2;
    tx_overflow = 1'b0;
    check("t5_sticky_set", 128'(overflow_sticky), 128'(1));
    tx_overflow = 1'b1;
    overflow_clr = 1'b1;
    @(posedge clk); #2;
    tx_overflow = 1'b0;
    overflow_clr = 1'b0;
    check("t5_sticky_both", 128'(overflow_sticky), 128'(1));
    overflow_clr = 1'b1;
    @(posedge clk); #2;
    overflow_clr = 1'b0;
    check("t5_sticky_clr", 128'(overflow_sticky), 128'(0));

    // Reset in the middle of a packet, then port 0 must win over port 3.
    add_pkt(0, 6, 64'h4400_0000_0000_0000, 32'h0A00_0301, 16'h4444);
    cyc = 0;
    while (pq[0].size() > 3 && cyc < 50) begin @(posedge clk); #3; cyc++; end
    if (cyc >= 50) timeout_fail("t6_start", cyc);
    do_reset("t6");
    add_pkt(0, 2, 64'h5500_0000_0000_0000, 32'h0A00_0401, 16'h5500);
    add_pkt(3, 2, 64'h5800_0000_0000_0000, 32'h0A00_0404, 16'h5800);
    cyc = 0;
    while (grant == '0 && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) timeout_fail("t6_grant", cyc);
    check("t6_first_grant", 128'(grant), 128'(4'b0001));
    wait_done("t6", 100);
    check("t6_pkt_count", 128'(pkt_count), 128'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
